// File: rtl/snoop_responder.sv
// Bus-side snoop responder: looks up snooped lines in a local tag/MESI directory,
// answers HIT/HITM/NOHIT, writes back modified lines and applies the MESI downgrade.
module snoop_responder #(
  parameter int ADDRESS_BITS = 32,
  parameter int OFFSET_BITS  = 6,
  parameter int SET_BITS     = 4,
  parameter int WAYS         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       snp_valid,
  output logic                       snp_ready,
  input  logic [2:0]                 snp_op,
  input  logic [ADDRESS_BITS-1:0]    snp_addr,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [1:0]                 res,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [ADDRESS_BITS-1:0]    wb_addr,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [ADDRESS_BITS-1:0]    fill_addr,
  input  logic [$clog2(WAYS)-1:0]    fill_way,
  input  logic [1:0]                 fill_mesi,
  input  logic                       clr,
  output logic                       proto_err
);

  localparam int TAG_W = ADDRESS_BITS - SET_BITS - OFFSET_BITS;
  localparam int WAY_W = $clog2(WAYS);
  localparam int SETS  = 2 ** SET_BITS;

  localparam logic [1:0] MESI_I = 2'd0, MESI_E = 2'd1, MESI_S = 2'd2, MESI_M = 2'd3;
  localparam logic [1:0] RES_HIT = 2'd0, RES_HITM = 2'd1, RES_NOHIT = 2'd2;
  localparam logic [2:0] OP_READ = 3'd1, OP_INV = 3'd3, OP_RWIM = 3'd4;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, RESP} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [1:0]       mesi_mem [SETS][WAYS];

  logic [2:0]              op_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [1:0]              res_q, nxt_q;
  logic                    upd_q, perr_q;
  logic [WAY_W-1:0]        way_q;
  logic [ADDRESS_BITS-1:0] wb_addr_q;

  logic [TAG_W-1:0]    snp_tag, fill_tag;
  logic [SET_BITS-1:0] snp_set, fill_set;

  assign snp_tag  = addr_q[ADDRESS_BITS-1 -: TAG_W];
  assign snp_set  = addr_q[OFFSET_BITS +: SET_BITS];
  assign fill_tag = fill_addr[ADDRESS_BITS-1 -: TAG_W];
  assign fill_set = fill_addr[OFFSET_BITS +: SET_BITS];

  logic unused_bits;
  assign unused_bits = ^{fill_addr[OFFSET_BITS-1:0]};

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [1:0]       hit_st;

  // Descending scan so the lowest matching way is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    hit_st  = MESI_I;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mesi_mem[snp_set][w] != MESI_I && tag_mem[snp_set][w] == snp_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
        hit_st  = mesi_mem[snp_set][w];
      end
    end
  end

  logic [1:0] res_d, nxt_d;
  logic       upd_d, perr_d, wb_d;

  always_comb begin
    res_d  = RES_NOHIT;
    nxt_d  = MESI_I;
    upd_d  = 1'b0;
    perr_d = 1'b0;
    wb_d   = 1'b0;
    if (hit) begin
      case (op_q)
        OP_READ, OP_RWIM: begin
          upd_d = 1'b1;
          nxt_d = (op_q == OP_READ) ? MESI_S : MESI_I;
          wb_d  = (hit_st == MESI_M);
          res_d = (hit_st == MESI_M) ? RES_HITM : RES_HIT;
        end
        OP_INV: begin
          if (hit_st == MESI_S) begin
            res_d = RES_HIT;
            upd_d = 1'b1;
            nxt_d = MESI_I;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snp_valid && snp_ready) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = wb_d ? WB : RESP;
      WB:      if (wb_ready) state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      res_q     <= RES_NOHIT;
      nxt_q     <= MESI_I;
      upd_q     <= 1'b0;
      perr_q    <= 1'b0;
      way_q     <= '0;
      wb_addr_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) mesi_mem[s][w] <= MESI_I;
    end else begin
      if (clr) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) mesi_mem[s][w] <= MESI_I;
      end else begin
        if (state == IDLE && fill_valid) mesi_mem[fill_set][fill_way] <= fill_mesi;
        if (state == RESP && res_ready && upd_q) mesi_mem[snp_set][way_q] <= nxt_q;
      end
      if (snp_valid && snp_ready) begin
        op_q   <= snp_op;
        addr_q <= snp_addr;
      end
      if (state == LOOKUP) begin
        res_q     <= res_d;
        nxt_q     <= nxt_d;
        upd_q     <= upd_d;
        perr_q    <= perr_d;
        way_q     <= hit_way;
        wb_addr_q <= {addr_q[ADDRESS_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
      end
    end
  end

  // Tags need no reset: an entry is only meaningful while its MESI state is valid.
  always_ff @(posedge clk) begin
    if (state == IDLE && fill_valid && !clr) tag_mem[fill_set][fill_way] <= fill_tag;
  end

  assign snp_ready  = rst_n & (state == IDLE) & ~fill_valid & ~clr;
  assign fill_ready = rst_n & (state == IDLE);
  assign wb_valid   = (state == WB);
  assign wb_addr    = wb_addr_q;
  assign res_valid  = (state == RESP);
  assign res        = res_q;
  assign proto_err  = (state == RESP) & res_ready & perr_q & ~clr;

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed scenarios followed by random
// fills and snoops compared against a table-level MESI directory model.
module tb_snoop_responder;

  logic        clk, rst_n;
  logic        snp_valid, snp_ready;
  logic [2:0]  snp_op;
  logic [31:0] snp_addr;
  logic        res_valid, res_ready;
  logic [1:0]  res;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_addr;
  logic        fill_valid, fill_ready;
  logic [31:0] fill_addr;
  logic [1:0]  fill_way;
  logic [1:0]  fill_mesi;
  logic        clr, proto_err;

  snoop_responder dut (
    .clk(clk), .rst_n(rst_n),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .res_valid(res_valid), .res_ready(res_ready), .res(res),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
    .fill_way(fill_way), .fill_mesi(fill_mesi),
    .clr(clr), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Directory model: per set/way tag and MESI (0=I,1=E,2=S,3=M)
  int m_tag [16][4];
  int m_st  [16][4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) m_st[s][w] = 0;
  endfunction

  function automatic void predict(input int op, input logic [31:0] a, output int r,
                                  output bit wb, output bit perr, output bit upd,
                                  output int nst, output int way);
    int s  = int'(a[9:6]);
    int t  = int'(a >> 10);
    int st = 0;
    way = -1;
    for (int w = 0; w < 4; w++) begin
      if (m_st[s][w] != 0 && m_tag[s][w] == t) begin
        way = w;
        st  = m_st[s][w];
        break;
      end
    end
    r = 2; wb = 0; perr = 0; upd = 0; nst = st;
    if (way >= 0) begin
      case (op)
        1: begin r = (st == 3) ? 1 : 0; wb = (st == 3); upd = 1; nst = 2; end
        4: begin r = (st == 3) ? 1 : 0; wb = (st == 3); upd = 1; nst = 0; end
        3: if (st == 2) begin r = 0; upd = 1; nst = 0; end else perr = 1;
        default: ;
      endcase
    end
  endfunction

  task automatic do_fill(input logic [31:0] a, input int way, input int mesi);
    @(negedge clk);
    fill_valid = 1; fill_addr = a; fill_way = 2'(way); fill_mesi = 2'(mesi);
    #1 chk("fill_ready", 32'(fill_ready), 1);
    @(posedge clk);
    #1 fill_valid = 0;
    m_tag[a[9:6]][way] = int'(a >> 10);
    m_st[a[9:6]][way]  = mesi;
  endtask

  // Accept edge T, then observe the LOOKUP cycle T+1.
  task automatic accept(input int op, input logic [31:0] a);
    @(negedge clk);
    snp_valid = 1; snp_op = 3'(op); snp_addr = a;
    #1 chk("snp_ready_idle", 32'(snp_ready), 1);
    @(posedge clk);
    #1 snp_valid = 0;
    @(negedge clk);
    chk("lookup_res_valid", 32'(res_valid), 0);
    chk("lookup_wb_valid", 32'(wb_valid), 0);
    chk("lookup_snp_ready", 32'(snp_ready), 0);
  endtask

  task automatic snoop_exp(input int op, input logic [31:0] a, input int exp_res,
                           input bit exp_wb, input bit exp_perr, input int wbd, input int rsd);
    logic [31:0] line = a & 32'hFFFF_FFC0;
    accept(op, a);
    @(negedge clk);
    if (exp_wb) begin
      chk("wb_valid", 32'(wb_valid), 1);
      chk("wb_addr", wb_addr, line);
      chk("wb_res_valid", 32'(res_valid), 0);
      for (int i = 0; i < wbd; i++) begin
        @(negedge clk);
        chk("wb_hold_valid", 32'(wb_valid), 1);
        chk("wb_hold_addr", wb_addr, line);
      end
      wb_ready = 1;
      @(posedge clk);
      #1 wb_ready = 0;
      @(negedge clk);
    end else begin
      chk("no_wb", 32'(wb_valid), 0);
    end
    chk("res_valid", 32'(res_valid), 1);
    chk("res", 32'(res), 32'(exp_res));
    for (int i = 0; i < rsd; i++) begin
      @(negedge clk);
      chk("res_hold_valid", 32'(res_valid), 1);
      chk("res_hold", 32'(res), 32'(exp_res));
      chk("perr_idle", 32'(proto_err), 0);
    end
    res_ready = 1;
    #1 chk("proto_err", 32'(proto_err), 32'(exp_perr));
    @(posedge clk);
    #1 res_ready = 0;
    @(negedge clk);
    chk("res_dropped", 32'(res_valid), 0);
    chk("perr_pulse_end", 32'(proto_err), 0);
    chk("snp_ready_again", 32'(snp_ready), 1);
  endtask

  task automatic run_snoop(input int op, input logic [31:0] a, input int wbd, input int rsd);
    int r, nst, way;
    bit wb, perr, upd;
    predict(op, a, r, wb, perr, upd, nst, way);
    snoop_exp(op, a, r, wb, perr, wbd, rsd);
    if (upd) m_st[a[9:6]][way] = nst;
  endtask

  initial begin
    rst_n = 0; snp_valid = 0; snp_op = 0; snp_addr = 0; res_ready = 0; wb_ready = 0;
    fill_valid = 0; fill_addr = 0; fill_way = 0; fill_mesi = 0; clr = 0;
    m_clear();
    repeat (2) @(negedge clk);
    chk("rst_snp_ready", 32'(snp_ready), 0);
    chk("rst_fill_ready", 32'(fill_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    chk("rst_res", 32'(res), 2);
    chk("rst_wb_addr", wb_addr, 0);
    rst_n = 1;

    snoop_exp(1, 32'h0000_1000, 2, 0, 0, 0, 0);

    do_fill(32'h0000_1040, 2, 3);
    snoop_exp(1, 32'h0000_1064, 1, 1, 0, 3, 0);
    snoop_exp(1, 32'h0000_1064, 0, 0, 0, 0, 1);

    do_fill(32'h0000_2080, 0, 1);
    snoop_exp(4, 32'h0000_2080, 0, 0, 0, 0, 0);
    snoop_exp(4, 32'h0000_2080, 2, 0, 0, 0, 0);

    do_fill(32'h0000_3000, 1, 1);
    snoop_exp(3, 32'h0000_3000, 2, 0, 1, 0, 1);
    snoop_exp(1, 32'h0000_3000, 0, 0, 0, 0, 0);

    // Fill and snoop together: fill wins, snoop follows and sees the new line
    @(negedge clk);
    fill_valid = 1; fill_addr = 32'h0000_4000; fill_way = 3; fill_mesi = 2;
    snp_valid = 1; snp_op = 1; snp_addr = 32'h0000_4000;
    #1 chk("fill_prio_snp_ready", 32'(snp_ready), 0);
    chk("fill_prio_fill_ready", 32'(fill_ready), 1);
    @(posedge clk);
    #1 fill_valid = 0;
    snoop_exp(1, 32'h0000_4000, 0, 0, 0, 0, 0);

    // clr while a writeback is pending
    do_fill(32'h0000_5000, 0, 3);
    accept(1, 32'h0000_5000);
    @(negedge clk);
    chk("clr_pre_wb_valid", 32'(wb_valid), 1);
    clr = 1;
    @(posedge clk);
    #1 clr = 0;
    @(negedge clk);
    chk("clr_wb_valid", 32'(wb_valid), 0);
    chk("clr_res_valid", 32'(res_valid), 0);
    chk("clr_idle", 32'(snp_ready), 1);
    m_clear();
    snoop_exp(1, 32'h0000_5000, 2, 0, 0, 0, 0);
    snoop_exp(1, 32'h0000_1040, 2, 0, 0, 0, 0);
    snoop_exp(1, 32'h0000_4000, 2, 0, 0, 0, 0);

    // Reset while a result is waiting
    do_fill(32'h0000_6000, 1, 1);
    accept(1, 32'h0000_6000);
    @(negedge clk);
    chk("pre_rst_res_valid", 32'(res_valid), 1);
    #2 rst_n = 0;
    #1 chk("async_rst_res_valid", 32'(res_valid), 0);
    chk("async_rst_res", 32'(res), 2);
    chk("async_rst_snp_ready", 32'(snp_ready), 0);
    @(negedge clk);
    rst_n = 1;
    m_clear();
    snoop_exp(1, 32'h0000_6000, 2, 0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 6)
          | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0)
        do_fill(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        run_snoop(int'($urandom_range(0, 7)), a, int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Bus-side responder for the L1 MESI cache model. The cache initiates bus operations; this block answers bus operations issued by other caches.
- Each accepted snoop (bus op plus address) is looked up in a local tag/MESI directory, which is kept consistent by the cache through a fill port.
- Returns a snoop result (HIT / HITM / NOHIT).
- Issues a writeback for modified lines.
- Applies the MESI state change.

Parameters:
- ADDRESS_BITS, 32, physical address width.
- OFFSET_BITS, 6, byte-offset bits (64-byte line).
- SET_BITS, 4, index bits; 2**SET_BITS sets.
- WAYS, 4, associativity.
- TAG_W is derived: ADDRESS_BITS-SET_BITS-OFFSET_BITS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- snp_valid  in  1  snoop request valid
- snp_ready  out  1  responder can accept a snoop
- snp_op  in  3  bus op: 1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM; other codes reserved
- snp_addr  in  ADDRESS_BITS  snooped address
- res_valid  out  1  snoop result valid
- res_ready  in  1  result consumed
- res  out  2  snoop result: 0=HIT, 1=HITM, 2=NOHIT
- wb_valid  out  1  writeback (bus WRITE) request for a modified line
- wb_ready  in  1  writeback accepted
- wb_addr  out  ADDRESS_BITS  line-aligned writeback address (offset bits zero)
- fill_valid  in  1  local cache install/update request
- fill_ready  out  1  fill accepted this cycle
- fill_addr  in  ADDRESS_BITS  line address of fill
- fill_way  in  log2(WAYS)  target way (chosen by the cache's PLRU)
- fill_mesi  in  2  new state: M=3, E=1, S=2, I=0
- clr  in  1  synchronous clear of the whole directory
- proto_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (rst_n low, async):
  - All MESI entries become I; tags are don't-care.
  - FSM goes to IDLE.
  - snp_ready, fill_ready, res_valid, wb_valid, proto_err are 0; res=NOHIT(2); wb_addr=0.
- FSM states: IDLE, LOOKUP, WB, RESP.
- IDLE:
  - fill_ready=1.
  - snp_ready = ~fill_valid & ~clr. Fill has priority over a snoop in the same cycle.
  - A fill on fill_valid&fill_ready writes tag and fill_mesi into set[fill_addr], way fill_way. It is visible to a lookup starting the next cycle.
  - On snp_valid&snp_ready: latch op and addr, go to LOOKUP.
- LOOKUP (1 cycle):
  - Compare the tag against all ways with MESI!=I.
  - On multiple matches, the lowest way index wins.
  - Go to WB if hit state is M and op is READ or RWIM; otherwise go to RESP.
- WB:
  - wb_valid=1, wb_addr={tag,index,0}, both held stable until wb_ready.
  - On the handshake cycle, drop wb_valid and go to RESP.
- RESP:
  - res_valid=1, res held stable until res_ready.
  - On the handshake cycle, apply the state update, drop res_valid, return to IDLE.
  - snp_ready and fill_ready are 0 in LOOKUP, WB and RESP.
- Results and MESI updates (hit state -> result / next state):
  - READ: M -> HITM/S; E -> HIT/S; S -> HIT/S.
  - RWIM: M -> HITM/I; E or S -> HIT/I.
  - INVALIDATE: S -> HIT/I. M or E -> NOHIT, no change, proto_err pulse in the RESP handshake cycle.
  - WRITE: any state -> NOHIT, no change.
  - Miss or reserved op -> NOHIT, no change.
- Latency:
  - Accept at cycle T gives res_valid at T+2 with no writeback.
  - With a writeback: wb_valid at T+2, res_valid the cycle after the wb handshake.
  - Back-to-back snoops: the next accept is possible the cycle after the res handshake.
- clr:
  - Honoured in any state.
  - Next edge: all MESI=I, FSM=IDLE, res_valid=wb_valid=0.
  - Aborts any in-flight snoop without a state update.
  - clr beats a fill in the same cycle.
- Reset mid-transaction: immediate abort; outputs go to reset values asynchronously.

Test Plan:
- Reset, then READ snoop to an empty directory -> res_valid at T+2, res=NOHIT, no wb_valid, snp_ready=1 again after the handshake.
- Fill 0x0000_1040 way 2 as M; READ snoop 0x0000_1064 -> wb_valid with wb_addr=0x0000_1040. Hold wb_ready low 3 cycles: wb_valid/wb_addr stable. Then res=HITM; a later READ returns HIT (state S).
- Fill as E; RWIM snoop -> res=HIT, no writeback; a repeat RWIM returns NOHIT (state I).
- Fill as E; INVALIDATE snoop -> res=NOHIT, proto_err pulses exactly 1 cycle, state stays E (a following READ returns HIT).
- fill_valid and snp_valid together in IDLE -> fill accepted, snp_ready=0; the snoop is accepted next cycle and hits the new line.
- Assert clr while in WB -> next cycle IDLE, wb_valid=0, all lookups NOHIT. Drop rst_n while in RESP -> res_valid=0 immediately.
